// File: rtl/operand_loader.sv
// ---------------------------------------------------------------------------
// operand_loader
//
// Byte-serial operand front end for the 4x4 matmul core. The host fills a
// 32-byte operand bank (matrix A in rows 0-3, matrix B in rows 4-7) one
// element at a time. A load command streams both matrices to the systolic
// array as a skewed 7-beat wavefront, then the block waits for the core's
// completion pulse (or a timeout) and raises a level interrupt.
//
// Optional feature macro: SYNC_INPUTS_EN
//   defined   : write/load go through 2-flop synchronizers and a rising-edge
//               detector; select/data pins are delayed to line up with them.
//   undefined : write/load are used directly as single-cycle pulses.
//
// Ports
//   clk          in   clock, rising edge
//   clear        in   asynchronous active-low reset
//   en           in   global enable; 0 freezes the FSM and drops writes/loads
//   write        in   write strobe
//   load         in   start-stream strobe
//   reg_select   in   [2:0] row select (0-3 A rows, 4-7 B rows)
//   idx_select   in   [1:0] column index within the row
//   data_in      in   [DATA_W-1:0] write data
//   mm_done      in   completion pulse from the core
//   data_out     out  [DATA_W-1:0] registered readback of the selected element
//   a_bus        out  [4*DATA_W-1:0] A lanes, lane i at [DATA_W*i +: DATA_W]
//   b_bus        out  [4*DATA_W-1:0] B lanes, same packing
//   stream_valid out  beat on a_bus/b_bus is valid
//   stream_last  out  final beat of the wavefront
//   busy         out  FSM is streaming or waiting
//   interrupt    out  high while in DONE
//   timeout      out  DONE was reached by timeout
//   load_err     out  sticky; a load arrived while busy
// ---------------------------------------------------------------------------
module operand_loader #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                en,
  input  logic                write,
  input  logic                load,
  input  logic [2:0]          reg_select,
  input  logic [1:0]          idx_select,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                mm_done,
  output logic [DATA_W-1:0]   data_out,
  output logic [4*DATA_W-1:0] a_bus,
  output logic [4*DATA_W-1:0] b_bus,
  output logic                stream_valid,
  output logic                stream_last,
  output logic                busy,
  output logic                interrupt,
  output logic                timeout,
  output logic                load_err
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q;
  logic [2:0]          beat_q;
  logic [WAIT_W-1:0]   waitCnt_q;
  logic [DATA_W-1:0]   bank_q [8][4];
  logic [DATA_W-1:0]   bank_d [8][4];
  logic [DATA_W-1:0]   dataOut_q;
  logic [4*DATA_W-1:0] aBus_q;
  logic [4*DATA_W-1:0] bBus_q;
  logic                streamValid_q;
  logic                streamLast_q;
  logic                busy_q;
  logic                irq_q;
  logic                timeout_q;
  logic                loadErr_q;

  logic                writeEvt;
  logic                loadEvt;
  logic [2:0]          wrSel;
  logic [1:0]          wrIdx;
  logic [DATA_W-1:0]   wrData;
  logic                writeAcc;
  logic                loadAcc;
  logic                idleOrDone;
  logic [2:0]          beatSel;
  logic [2:0]          diff;
  logic [4*DATA_W-1:0] aNext;
  logic [4*DATA_W-1:0] bNext;

`ifdef SYNC_INPUTS_EN
  logic [2:0]                 wrSync_q;
  logic [2:0]                 ldSync_q;
  logic                       writeEvt_q;
  logic                       loadEvt_q;
  logic [5+DATA_W-1:0]        addrPipe_q [3];

  // Two synchronizer flops plus one history flop per strobe; the event is
  // registered, so it appears three edges after the pin. The select/data
  // pins ride a matching three-deep pipe so they line up with the event.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wrSync_q   <= '0;
      ldSync_q   <= '0;
      writeEvt_q <= 1'b0;
      loadEvt_q  <= 1'b0;
      addrPipe_q <= '{default: '0};
    end else begin
      wrSync_q      <= {wrSync_q[1:0], write};
      ldSync_q      <= {ldSync_q[1:0], load};
      writeEvt_q    <= wrSync_q[1] & ~wrSync_q[2];
      loadEvt_q     <= ldSync_q[1] & ~ldSync_q[2];
      addrPipe_q[0] <= {reg_select, idx_select, data_in};
      addrPipe_q[1] <= addrPipe_q[0];
      addrPipe_q[2] <= addrPipe_q[1];
    end
  end

  assign writeEvt = writeEvt_q;
  assign loadEvt  = loadEvt_q;
  assign {wrSel, wrIdx, wrData} = addrPipe_q[2];
`else
  assign writeEvt = write;
  assign loadEvt  = load;
  assign wrSel    = reg_select;
  assign wrIdx    = idx_select;
  assign wrData   = data_in;
`endif

  assign idleOrDone = (state_q == IDLE) || (state_q == DONE);
  assign writeAcc   = en & writeEvt & idleOrDone;
  assign loadAcc    = en & loadEvt & idleOrDone;

  // Next bank contents. The stream outputs are computed from this so that a
  // write landing on the same edge as the load is already in beat 0.
  always_comb begin
    bank_d = bank_q;
    if (writeAcc) begin
      bank_d[wrSel][wrIdx] = wrData;
    end
  end

  // Beat about to be presented: 0 when a stream starts, otherwise the one
  // after the current beat.
  assign beatSel = (state_q == STREAM) ? (beat_q + 3'd1) : 3'd0;

  // Skewed wavefront: A lane i carries A[i][t-i], B lane j carries
  // B[t-j][j], each only while the skewed index falls inside the row.
  always_comb begin
    aNext = '0;
    bNext = '0;
    diff  = '0;
    for (int l = 0; l < 4; l++) begin
      diff = beatSel - 3'(l);
      if ((beatSel >= 3'(l)) && (diff <= 3'd3)) begin
        aNext[DATA_W*l +: DATA_W] = bank_d[{1'b0, 2'(l)}][diff[1:0]];
        bNext[DATA_W*l +: DATA_W] = bank_d[{1'b1, diff[1:0]}][2'(l)];
      end
    end
  end

  // Operand bank storage.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      bank_q <= '{default: '0};
    end else begin
      bank_q <= bank_d;
    end
  end

  // Readback runs every cycle, independent of state and enable.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      dataOut_q <= '0;
    end else begin
      dataOut_q <= bank_q[reg_select][idx_select];
    end
  end

  // Control FSM with all status and stream outputs registered. With en low
  // the state and counters hold and only stream_valid is dropped; the next
  // beat follows once en returns.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      waitCnt_q     <= '0;
      aBus_q        <= '0;
      bBus_q        <= '0;
      streamValid_q <= 1'b0;
      streamLast_q  <= 1'b0;
      busy_q        <= 1'b0;
      irq_q         <= 1'b0;
      timeout_q     <= 1'b0;
      loadErr_q     <= 1'b0;
    end else if (!en) begin
      streamValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (loadAcc) begin
            state_q       <= STREAM;
            beat_q        <= 3'd0;
            aBus_q        <= aNext;
            bBus_q        <= bNext;
            streamValid_q <= 1'b1;
            streamLast_q  <= 1'b0;
            busy_q        <= 1'b1;
            irq_q         <= 1'b0;
            timeout_q     <= 1'b0;
            loadErr_q     <= 1'b0;
          end else if (writeAcc && (state_q == DONE)) begin
            state_q   <= IDLE;
            irq_q     <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        STREAM: begin
          if (loadEvt) begin
            loadErr_q <= 1'b1;
          end
          if (beat_q == 3'd6) begin
            state_q       <= WAIT;
            waitCnt_q     <= '0;
            aBus_q        <= '0;
            bBus_q        <= '0;
            streamValid_q <= 1'b0;
            streamLast_q  <= 1'b0;
          end else begin
            beat_q        <= beat_q + 3'd1;
            aBus_q        <= aNext;
            bBus_q        <= bNext;
            streamValid_q <= 1'b1;
            streamLast_q  <= (beat_q == 3'd5);
          end
        end
        WAIT: begin
          if (loadEvt) begin
            loadErr_q <= 1'b1;
          end
          if (mm_done) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            irq_q   <= 1'b1;
          end else if (waitCnt_q == WAIT_LAST) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            irq_q     <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_out     = dataOut_q;
  assign a_bus        = aBus_q;
  assign b_bus        = bBus_q;
  assign stream_valid = streamValid_q;
  assign stream_last  = streamLast_q;
  assign busy         = busy_q;
  assign interrupt    = irq_q;
  assign timeout      = timeout_q;
  assign load_err     = loadErr_q;

endmodule

// File: tb/tb_operand_loader.sv
// ---------------------------------------------------------------------------
// tb_operand_loader
//
// Scoreboard bench for operand_loader (default build, direct strobes).
// Stimulus tasks update a matrix-level model of the operand bank and, on an
// accepted load, push the seven expected wavefront beats into a queue. A
// free-running monitor pops a beat whenever stream_valid is seen and
// compares it. Status outputs are checked directly from the main sequence.
// ---------------------------------------------------------------------------
module tb_operand_loader;

  localparam int DW  = 8;
  localparam int TMO = 16;

  typedef struct packed {
    logic [4*DW-1:0] a;
    logic [4*DW-1:0] b;
    logic            last;
  } beat_t;

  logic            clk;
  logic            clear;
  logic            en;
  logic            write;
  logic            load;
  logic [2:0]      reg_select;
  logic [1:0]      idx_select;
  logic [DW-1:0]   data_in;
  logic            mm_done;
  logic [DW-1:0]   data_out;
  logic [4*DW-1:0] a_bus;
  logic [4*DW-1:0] b_bus;
  logic            stream_valid;
  logic            stream_last;
  logic            busy;
  logic            interrupt;
  logic            timeout;
  logic            load_err;

  int nCompared;
  int nMismatched;

  logic [DW-1:0] refBank [8][4];
  beat_t         expQ [$];

  operand_loader #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .clear        (clear),
    .en           (en),
    .write        (write),
    .load         (load),
    .reg_select   (reg_select),
    .idx_select   (idx_select),
    .data_in      (data_in),
    .mm_done      (mm_done),
    .data_out     (data_out),
    .a_bus        (a_bus),
    .b_bus        (b_bus),
    .stream_valid (stream_valid),
    .stream_last  (stream_last),
    .busy         (busy),
    .interrupt    (interrupt),
    .timeout      (timeout),
    .load_err     (load_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Expected wavefront from the matrix view: at step t, row i of A feeds
  // lane i with element k = t-i, and column j of B feeds lane j with
  // element k = t-j, while k lies inside the 4-element row/column.
  task automatic pushStream();
    beat_t bt;
    int    k;
    for (int t = 0; t < 7; t++) begin
      bt = '0;
      for (int lane = 0; lane < 4; lane++) begin
        k = t - lane;
        if (k >= 0 && k < 4) begin
          bt.a[DW*lane +: DW] = refBank[lane][k];
          bt.b[DW*lane +: DW] = refBank[4 + k][lane];
        end
      end
      bt.last = (t == 6);
      expQ.push_back(bt);
    end
  endtask

  // Drive one strobe cycle starting at the current falling edge. The caller
  // states whether the bench expects the DUT to accept it.
  task automatic applyStimulus(input bit doWr, input int sel, input int idx,
                               input int data, input bit doLd, input bit accepted);
    write      = doWr;
    load       = doLd;
    reg_select = 3'(sel);
    idx_select = 2'(idx);
    data_in    = DW'(data);
    if (accepted && doWr) refBank[sel][idx] = DW'(data);
    if (accepted && doLd) pushStream();
    @(negedge clk);
    write = 1'b0;
    load  = 1'b0;
  endtask

  task automatic readCheck(input int sel, input int idx);
    reg_select = 3'(sel);
    idx_select = 2'(idx);
    @(negedge clk);
    checkOutput("readback", 64'(data_out), 64'(refBank[sel][idx]));
  endtask

  task automatic randomWrites(input int n);
    for (int w = 0; w < n; w++) begin
      applyStimulus(1'b1, int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
                    int'($urandom_range(255, 0)), 1'b0, 1'b1);
    end
  endtask

  // Let the stream and WAIT run, then pulse mm_done after the given number
  // of falling edges and expect the interrupt on the next one.
  task automatic finishWithDone(input int edgesToGo);
    repeat (edgesToGo) @(negedge clk);
    checkOutput("irqBeforeDone", 64'(interrupt), 64'd0);
    checkOutput("busyInWait", 64'(busy), 64'd1);
    mm_done = 1'b1;
    @(negedge clk);
    mm_done = 1'b0;
    checkOutput("irqAfterDone", 64'(interrupt), 64'd1);
    checkOutput("timeoutAfterDone", 64'(timeout), 64'd0);
    checkOutput("busyAfterDone", 64'(busy), 64'd0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    beat_t got;
    beat_t want;
    if (clear && stream_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedBeat", 64'd1, 64'd0);
      end else begin
        want = expQ.pop_front();
        got  = '{a: a_bus, b: b_bus, last: stream_last};
        checkOutput("beatA", 64'(got.a), 64'(want.a));
        checkOutput("beatB", 64'(got.b), 64'(want.b));
        checkOutput("beatLast", 64'(got.last), 64'(want.last));
      end
    end
  end

  // Guard against a hung run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int specA [4][4];
    int specB [4][4];
    int d;
    nCompared   = 0;
    nMismatched = 0;
    specA = '{'{0,2,3,1}, '{0,2,0,3}, '{1,2,4,4}, '{0,2,4,2}};
    specB = '{'{2,2,0,0}, '{2,4,4,0}, '{4,1,4,1}, '{2,4,1,4}};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        refBank[r][c] = '0;

    clear = 1'b0; en = 1'b1; write = 1'b0; load = 1'b0; mm_done = 1'b0;
    reg_select = '0; idx_select = '0; data_in = '0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rstDataOut", 64'(data_out), 64'd0);
    checkOutput("rstABus", 64'(a_bus), 64'd0);
    checkOutput("rstBBus", 64'(b_bus), 64'd0);
    checkOutput("rstStatus", 64'({stream_valid, stream_last, busy, interrupt, timeout, load_err}), 64'd0);
    clear = 1'b1;
    @(negedge clk);

    // Write then readback, everything else reads 0
    applyStimulus(1'b1, 7, 3, 8'h08, 1'b0, 1'b1);
    readCheck(7, 3);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        readCheck(r, c);

    // With en low, writes and loads are ignored
    en = 1'b0;
    applyStimulus(1'b1, 2, 1, 8'hAA, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    en = 1'b1;
    @(negedge clk);
    checkOutput("enLowBusy", 64'(busy), 64'd0);
    readCheck(2, 1);

    // Full stream with the reference matrices, done at wait count 3
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        applyStimulus(1'b1, r, c, specA[r][c], 1'b0, 1'b1);
        applyStimulus(1'b1, 4 + r, c, specB[r][c], 1'b0, 1'b1);
      end
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b1);
    checkOutput("beat0A", 64'(a_bus), 64'h0000_0000);
    checkOutput("beat0B", 64'(b_bus), 64'h0000_0002);
    @(negedge clk);
    checkOutput("beat1A", 64'(a_bus), 64'h0000_0002);
    checkOutput("beat1B", 64'(b_bus), 64'h0000_0202);
    finishWithDone(9);
    applyStimulus(1'b1, 0, 0, 8'h11, 1'b0, 1'b1);
    checkOutput("irqClearedByWrite", 64'(interrupt), 64'd0);

    // Timeout path
    randomWrites(4);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b1);
    repeat (6 + TMO) @(negedge clk);
    checkOutput("irqLastWaitCycle", 64'(interrupt), 64'd0);
    checkOutput("busyLastWaitCycle", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("irqOnTimeout", 64'(interrupt), 64'd1);
    checkOutput("timeoutFlag", 64'(timeout), 64'd1);

    // Load accepted in DONE, then a load while streaming
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b1);
    checkOutput("timeoutClearedByLoad", 64'(timeout), 64'd0);
    checkOutput("irqClearedByLoad", 64'(interrupt), 64'd0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    checkOutput("loadErrSet", 64'(load_err), 64'd1);
    finishWithDone(8);
    checkOutput("loadErrSticky", 64'(load_err), 64'd1);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b1);
    checkOutput("loadErrCleared", 64'(load_err), 64'd0);
    finishWithDone(7);

    // Same-cycle write and load: the stream carries the new value
    applyStimulus(1'b1, 0, 0, 5, 1'b1, 1'b1);
    checkOutput("sameCycleLane0", 64'(a_bus[DW-1:0]), 64'd5);
    finishWithDone(8);

    // Randomized rounds
    for (int round = 0; round < 4; round++) begin
      randomWrites(6);
      applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b1);
      d = int'($urandom_range(TMO - 2, 0));
      finishWithDone(7 + d);
      for (int q = 0; q < 3; q++)
        readCheck(int'($urandom_range(7, 0)), int'($urandom_range(3, 0)));
    end

    // Clear at beat 3
    randomWrites(5);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    clear = 1'b0;
    #1;
    checkOutput("clearABus", 64'(a_bus), 64'd0);
    checkOutput("clearBBus", 64'(b_bus), 64'd0);
    checkOutput("clearStatus", 64'({stream_valid, stream_last, busy, interrupt}), 64'd0);
    expQ.delete();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        refBank[r][c] = '0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        readCheck(r, c);
    checkOutput("idleAfterClear", 64'(busy), 64'd0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b1);
    finishWithDone(7);

    repeat (3) @(negedge clk);
    checkOutput("pendingBeats", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
